// File: rtl/prm_edge_mask_accum.sv
// Feeds registered obstacle codes to the PRM checker bank, ORs the returned edge masks
// into a sticky blocked vector, then popcounts it. Optional counters: PRM_MASK_OBS_CNT_EN.
module prm_edge_mask_accum #(
    parameter int NUM_EDGES = 1024,
    parameter int CODE_W    = 15,
    parameter int SCAN_W    = 16,
    parameter int CNT_W     = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 obs_valid,
    output logic                 obs_ready,
    input  logic [CODE_W-1:0]    obs_code,
    input  logic                 obs_last,
    output logic [CODE_W-1:0]    chk_code,
    input  logic [NUM_EDGES-1:0] chk_mask,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_EDGES-1:0] edge_blocked,
`ifdef PRM_MASK_OBS_CNT_EN
    output logic [15:0]          obs_cnt,
    output logic [15:0]          hit_cnt,
`endif
    output logic [CNT_W-1:0]     blocked_cnt
);

    localparam int NUM_SCANS = NUM_EDGES / SCAN_W;
    localparam int IDX_W     = (NUM_SCANS > 1) ? $clog2(NUM_SCANS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DRAIN,
        COUNT,
        DONE
    } stateT;

    stateT                state_q, state_d;
    logic [CODE_W-1:0]    chkCode_q, chkCode_d;
    logic                 accEn_q, accEn_d;
    logic [NUM_EDGES-1:0] edgeBlocked_q, edgeBlocked_d;
    logic [CNT_W-1:0]     blockedCnt_q, blockedCnt_d;
    logic [IDX_W-1:0]     scanIdx_q, scanIdx_d;
    logic                 done_q, done_d;
    logic [SCAN_W-1:0]    scanSlice;
    logic [CNT_W-1:0]     sliceCnt;
`ifdef PRM_MASK_OBS_CNT_EN
    logic [15:0]          obsCnt_q, obsCnt_d;
    logic [15:0]          hitCnt_q, hitCnt_d;
`endif

    // Popcount of the slice currently addressed by the scan index
    always_comb begin
        scanSlice = edgeBlocked_q[int'(scanIdx_q) * SCAN_W +: SCAN_W];
        sliceCnt  = '0;
        for (int i = 0; i < SCAN_W; i++) begin
            sliceCnt = sliceCnt + CNT_W'(scanSlice[i]);
        end
    end

    always_comb begin
        state_d       = state_q;
        chkCode_d     = chkCode_q;
        accEn_d       = 1'b0;
        edgeBlocked_d = edgeBlocked_q;
        blockedCnt_d  = blockedCnt_q;
        scanIdx_d     = scanIdx_q;
        done_d        = 1'b0;
`ifdef PRM_MASK_OBS_CNT_EN
        obsCnt_d      = obsCnt_q;
        hitCnt_d      = hitCnt_q;
`endif

        // The bank is combinational, so the mask for an accepted code arrives one cycle later
        if (accEn_q) begin
            edgeBlocked_d = edgeBlocked_q | chk_mask;
`ifdef PRM_MASK_OBS_CNT_EN
            if ((|chk_mask) && (hitCnt_q != 16'hFFFF)) begin
                hitCnt_d = hitCnt_q + 16'd1;
            end
`endif
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d       = ACCUM;
                    edgeBlocked_d = '0;
                    blockedCnt_d  = '0;
`ifdef PRM_MASK_OBS_CNT_EN
                    obsCnt_d      = '0;
                    hitCnt_d      = '0;
`endif
                end
            end
            ACCUM: begin
                if (obs_valid) begin
                    chkCode_d = obs_code;
                    accEn_d   = 1'b1;
`ifdef PRM_MASK_OBS_CNT_EN
                    if (obsCnt_q != 16'hFFFF) begin
                        obsCnt_d = obsCnt_q + 16'd1;
                    end
`endif
                    if (obs_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d      = COUNT;
                scanIdx_d    = '0;
                blockedCnt_d = '0;
            end
            COUNT: begin
                blockedCnt_d = blockedCnt_q + sliceCnt;
                scanIdx_d    = scanIdx_q + IDX_W'(1);
                if (scanIdx_q == IDX_W'(NUM_SCANS - 1)) begin
                    scanIdx_d = '0;
                    state_d   = DONE;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            chkCode_q     <= '0;
            accEn_q       <= 1'b0;
            edgeBlocked_q <= '0;
            blockedCnt_q  <= '0;
            scanIdx_q     <= '0;
            done_q        <= 1'b0;
`ifdef PRM_MASK_OBS_CNT_EN
            obsCnt_q      <= '0;
            hitCnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            chkCode_q     <= chkCode_d;
            accEn_q       <= accEn_d;
            edgeBlocked_q <= edgeBlocked_d;
            blockedCnt_q  <= blockedCnt_d;
            scanIdx_q     <= scanIdx_d;
            done_q        <= done_d;
`ifdef PRM_MASK_OBS_CNT_EN
            obsCnt_q      <= obsCnt_d;
            hitCnt_q      <= hitCnt_d;
`endif
        end
    end

    assign obs_ready    = (state_q == ACCUM);
    assign busy         = (state_q == ACCUM) || (state_q == DRAIN) || (state_q == COUNT);
    assign done         = done_q;
    assign chk_code     = chkCode_q;
    assign edge_blocked = edgeBlocked_q;
    assign blocked_cnt  = blockedCnt_q;
`ifdef PRM_MASK_OBS_CNT_EN
    assign obs_cnt      = obsCnt_q;
    assign hit_cnt      = hitCnt_q;
`endif

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Bench for prm_edge_mask_accum with a 32-edge behavioural checker bank:
// mask bit i is set when code[4:0] == i.
module tb_prm_edge_mask_accum;

    localparam int NE   = 32;
    localparam int CW   = 15;
    localparam int SW   = 8;
    localparam int CNTW = 6;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            start     = 1'b0;
    logic            obs_valid = 1'b0;
    logic            obs_last  = 1'b0;
    logic [CW-1:0]   obs_code  = '0;
    logic            obs_ready;
    logic            busy;
    logic            done;
    logic [CW-1:0]   chk_code;
    logic [NE-1:0]   chk_mask;
    logic [NE-1:0]   edge_blocked;
    logic [CNTW-1:0] blocked_cnt;
`ifdef PRM_MASK_OBS_CNT_EN
    logic [15:0]     obs_cnt;
    logic [15:0]     hit_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int doneCount   = 0;
    bit forceZero40 = 1'b0;
    int accepted[$];

    prm_edge_mask_accum #(
        .NUM_EDGES (NE),
        .CODE_W    (CW),
        .SCAN_W    (SW),
        .CNT_W     (CNTW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .obs_valid    (obs_valid),
        .obs_ready    (obs_ready),
        .obs_code     (obs_code),
        .obs_last     (obs_last),
        .chk_code     (chk_code),
        .chk_mask     (chk_mask),
        .busy         (busy),
        .done         (done),
        .edge_blocked (edge_blocked),
`ifdef PRM_MASK_OBS_CNT_EN
        .obs_cnt      (obs_cnt),
        .hit_cnt      (hit_cnt),
`endif
        .blocked_cnt  (blocked_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural checker bank, optionally blind to code 40
    always_comb begin
        chk_mask = (forceZero40 && chk_code == 15'd40) ? '0 : (32'd1 << chk_code[4:0]);
    end

    always @(negedge clk) begin
        if (done === 1'b1) doneCount++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer one code, hold it until accepted, then idle for gap cycles
    task automatic applyStimulus(input logic [CW-1:0] code, input bit last, input int gap);
        int t;
        obs_valid = 1'b1;
        obs_code  = code;
        obs_last  = last;
        t = 0;
        while (obs_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) checkOutput("ready_timeout", 64'd0, 64'd1);
        tick();
        accepted.push_back(int'(code));
        obs_valid = 1'b0;
        obs_last  = 1'b0;
        checkOutput("chk_code", 64'(chk_code), 64'(code));
        repeat (gap) tick();
    endtask

    task automatic waitDone(output int edges, output bit readySeen);
        edges     = 0;
        readySeen = (obs_ready === 1'b1);
        while (done !== 1'b1 && edges < 200) begin
            tick();
            edges++;
            if (obs_ready === 1'b1) readySeen = 1'b1;
        end
        if (done !== 1'b1) checkOutput("done_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] modelMask();
        logic [31:0] m = '0;
        foreach (accepted[k]) begin
            if (!(forceZero40 && accepted[k] == 40)) m = m | (32'd1 << (accepted[k] % 32));
        end
        return m;
    endfunction

    function automatic int modelCount(input logic [31:0] m);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m[i]);
        return c;
    endfunction

    function automatic int modelHits();
        int h = 0;
        foreach (accepted[k]) begin
            if (!(forceZero40 && accepted[k] == 40)) h++;
        end
        return h;
    endfunction

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_chk_code"}, 64'(chk_code), 64'd0);
        checkOutput({tag, "_obs_ready"}, 64'(obs_ready), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_edge_blocked"}, 64'(edge_blocked), 64'd0);
        checkOutput({tag, "_blocked_cnt"}, 64'(blocked_cnt), 64'd0);
    endtask

    initial begin
        int  edges;
        bit  readySeen;
        int  doneSnap;
        int  n;
        logic [CW-1:0] code;
        logic [31:0]   expMask;

        // Power-on reset
        repeat (2) @(negedge clk);
        checkIdleZero("por");
        rst_n = 1'b1;
        tick();

        // Reset mid-ACCUM after three codes
        pulseStart();
        accepted.delete();
        applyStimulus(15'd1, 1'b0, 0);
        applyStimulus(15'd2, 1'b0, 0);
        applyStimulus(15'd3, 1'b0, 0);
        doneSnap = doneCount;
        rst_n = 1'b0;
        #1;
        checkIdleZero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick();
        checkOutput("midreset_idle_busy", 64'(busy), 64'd0);
        checkOutput("midreset_no_done", 64'(doneCount - doneSnap), 64'd0);

        // Codes 5, 9, 5 back to back
        pulseStart();
        accepted.delete();
        checkOutput("f1_busy", 64'(busy), 64'd1);
        doneSnap = doneCount;
        applyStimulus(15'd5, 1'b0, 0);
        applyStimulus(15'd9, 1'b0, 0);
        applyStimulus(15'd5, 1'b1, 0);
        waitDone(edges, readySeen);
        checkOutput("f1_latency", 64'(edges), 64'd5);
        checkOutput("f1_mask", 64'(edge_blocked), 64'h0000_0220);
        checkOutput("f1_cnt", 64'(blocked_cnt), 64'd2);
        checkOutput("f1_busy_done", 64'(busy), 64'd0);
        tick();
        checkOutput("f1_done_once", 64'(done), 64'd0);
        checkOutput("f1_done_pulses", 64'(doneCount - doneSnap), 64'd1);
        checkOutput("f1_hold_mask", 64'(edge_blocked), 64'h0000_0220);

        // Backpressure: valid 1,0,1,0 with codes 0 and 31
        pulseStart();
        accepted.delete();
        applyStimulus(15'd0, 1'b0, 1);
        applyStimulus(15'd31, 1'b1, 0);
        waitDone(edges, readySeen);
        checkOutput("f2_ready_low", 64'(readySeen), 64'd0);
        checkOutput("f2_mask", 64'(edge_blocked), 64'h8000_0001);
        checkOutput("f2_cnt", 64'(blocked_cnt), 64'd2);

        // All 32 edges, start pulsed mid-COUNT
        pulseStart();
        accepted.delete();
        for (int i = 0; i < 32; i++) applyStimulus(CW'(i), (i == 31), 0);
        tick();
        tick();
        pulseStart();
        checkOutput("f3_start_ignored_busy", 64'(busy), 64'd1);
        waitDone(edges, readySeen);
        checkOutput("f3_mask", 64'(edge_blocked), 64'hFFFF_FFFF);
        checkOutput("f3_cnt", 64'(blocked_cnt), 64'd32);
        pulseStart();
        accepted.delete();
        checkOutput("f3_restart_mask", 64'(edge_blocked), 64'd0);
        checkOutput("f3_restart_cnt", 64'(blocked_cnt), 64'd0);
        checkOutput("f3_restart_busy", 64'(busy), 64'd1);

        // Single code marked last on the first beat
        applyStimulus(15'd7, 1'b1, 0);
        waitDone(edges, readySeen);
        checkOutput("f4_latency", 64'(edges), 64'd5);
        checkOutput("f4_mask", 64'(edge_blocked), 64'h0000_0080);
        checkOutput("f4_cnt", 64'(blocked_cnt), 64'd1);

        // Randomised frames against the reference model
        for (int f = 0; f < 6; f++) begin
            pulseStart();
            accepted.delete();
            n = int'($urandom_range(1, 8));
            for (int k = 0; k < n; k++) begin
                code = CW'($urandom_range(0, 32767));
                applyStimulus(code, (k == n - 1), (k == n - 1) ? 0 : int'($urandom_range(0, 2)));
            end
            waitDone(edges, readySeen);
            expMask = modelMask();
            checkOutput("rnd_mask", 64'(edge_blocked), 64'(expMask));
            checkOutput("rnd_cnt", 64'(blocked_cnt), 64'(modelCount(expMask)));
`ifdef PRM_MASK_OBS_CNT_EN
            checkOutput("rnd_obs_cnt", 64'(obs_cnt), 64'(accepted.size()));
            checkOutput("rnd_hit_cnt", 64'(hit_cnt), 64'(modelHits()));
`endif
        end

`ifdef PRM_MASK_OBS_CNT_EN
        // Counters with the bank blind to code 40
        forceZero40 = 1'b1;
        pulseStart();
        accepted.delete();
        applyStimulus(15'd3, 1'b0, 0);
        applyStimulus(15'd40, 1'b0, 0);
        applyStimulus(15'd35, 1'b1, 0);
        waitDone(edges, readySeen);
        checkOutput("cnt_obs", 64'(obs_cnt), 64'd3);
        checkOutput("cnt_hit", 64'(hit_cnt), 64'd2);
        checkOutput("cnt_mask", 64'(edge_blocked), 64'h0000_0008);
        checkOutput("cnt_blocked", 64'(blocked_cnt), 64'd1);
        forceZero40 = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
